vga_fb_mem: RTL

Parametrised dual-port framebuffer memory for the VGA path. Port A is the game-logic read/write port with per-lane byte enables; port B is the read-only scan-out port. A built-in clear engine fills the whole array with one value in 2^ADDR_WIDTH cycles, so a full screen can be blanked without the game FSM stepping through addresses. Read-during-write on either port returns new data, and an optional output pipeline stage is available for timing closure.

---
 rtl/vga_fb_mem_if.sv | 28 ++
 rtl/vga_fb_mem.sv | 124 ++++++++++++
 2 files changed

// File: rtl/vga_fb_mem_if.sv
// rtl/vga_fb_mem_if.sv - framebuffer port A/B, clear-engine signal bundle
interface vga_fb_mem_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int LANES      = 1
);
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_we;
    logic [LANES-1:0]      a_be;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_rdata;
    logic                  clr_start;
    logic [DATA_WIDTH-1:0] clr_data;
    logic                  busy;
    logic                  clr_done;

    modport master (
        output a_addr, a_wdata, a_we, a_be, b_addr, clr_start, clr_data,
        input  a_rdata, b_rdata, busy, clr_done
    );

    modport slave (
        input  a_addr, a_wdata, a_we, a_be, b_addr, clr_start, clr_data,
        output a_rdata, b_rdata, busy, clr_done
    );
endinterface

// File: rtl/vga_fb_mem.sv
// rtl/vga_fb_mem.sv - dual-port framebuffer with byte lanes and clear engine
module vga_fb_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int LANES      = 1,
    parameter int OUT_REG    = 0
) (
    input  logic         clk,
    input  logic         rst,
    vga_fb_mem_if.slave  mem_io
);
    localparam int LW    = DATA_WIDTH / LANES;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] a_rd_q, b_rd_q;

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    logic                  clr_wr, a_wr, wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] a_old, a_merged, wr_word, a_next, b_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_io.clr_start) begin
                    fill_d  = mem_io.clr_data;
                    cnt_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                // Terminate on the last address rather than on counter wrap.
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clr_wr = (state_q == CLEAR);
    assign a_wr   = mem_io.a_we && !clr_wr;
    assign wr_en  = a_wr || clr_wr;

    always_comb begin
        a_old    = ram[mem_io.a_addr];
        a_merged = a_old;
        for (int i = 0; i < LANES; i++) begin
            if (mem_io.a_be[i]) a_merged[i*LW +: LW] = mem_io.a_wdata[i*LW +: LW];
        end
    end

    assign wr_addr = clr_wr ? cnt_q  : mem_io.a_addr;
    assign wr_word = clr_wr ? fill_q : a_merged;

    // Both read ports see the word as it will be after this edge's write.
    assign a_next = (wr_en && wr_addr == mem_io.a_addr) ? wr_word : ram[mem_io.a_addr];
    assign b_next = (wr_en && wr_addr == mem_io.b_addr) ? wr_word : ram[mem_io.b_addr];

    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= wr_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rd_q <= '0;
            b_rd_q <= '0;
        end else begin
            a_rd_q <= a_next;
            b_rd_q <= b_next;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] a_out_q, b_out_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_out_q <= '0;
                    b_out_q <= '0;
                end else begin
                    a_out_q <= a_rd_q;
                    b_out_q <= b_rd_q;
                end
            end
            assign mem_io.a_rdata = a_out_q;
            assign mem_io.b_rdata = b_out_q;
        end else begin : g_no_out_reg
            assign mem_io.a_rdata = a_rd_q;
            assign mem_io.b_rdata = b_rd_q;
        end
    endgenerate

    assign mem_io.busy     = clr_wr;
    assign mem_io.clr_done = done_q;
endmodule
